// File: rtl/dcache_wt_pkg.sv
// dcache_wt shared definitions: FSM encoding and address slicing.
// Direct-mapped write-through cache with one-word lines.
package dcache_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_LINES  = 16;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int OFF_W      = 2;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int addr_w);
    return addr_w - $clog2(lines) - OFF_W;
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// Backing-memory req/ack bus between dcache_wt and data memory.
// master = cache side, slave = memory side.
interface dcache_wt_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_wt_array.sv
// Tag/data/valid storage: comb read, sync write.
// Only the valid bits are cleared by reset.
module dcache_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// dcache_wt top: FSM, request latches and memory handshake.
// Hits are served combinationally; misses and stores stall.
module dcache_wt
  import dcache_defs::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  dcache_wt_if.master       mem
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, ADDR_W);

  state_e state_q, state_d;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [IDX_W-1:0]  cpu_idx, req_idx, rd_idx;
  logic [TAG_W-1:0]  cpu_tag, req_tag, cmp_tag;
  logic              rd_valid, hit, start;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              unused_bits;

  assign unused_bits = ^data_address[1:0];

  assign cpu_idx = data_address[IDX_W+1:2];
  assign cpu_tag = data_address[ADDR_W-1:IDX_W+2];
  assign req_idx = addr_q[IDX_W+1:2];
  assign req_tag = addr_q[ADDR_W-1:IDX_W+2];

  // IDLE looks up the CPU address, BUSY re-checks the latched one
  assign rd_idx  = (state_q == IDLE) ? cpu_idx : req_idx;
  assign cmp_tag = (state_q == IDLE) ? cpu_tag : req_tag;
  assign hit     = rd_valid && (rd_tag == cmp_tag);

  assign start = rst && (state_q == IDLE) &&
                 (mem_write || (mem_read && !hit));

  dcache_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mem.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    data_out = '0;
    wr_en    = 1'b0;
    wr_data  = mem.mem_rdata;
    unique case (state_q)
      IDLE: begin
        stall = start;
        if (rst && mem_read && !mem_write && hit)
          data_out = rd_data;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          // stores only refresh a line that already holds this tag
          wr_en   = !we_q || hit;
          wr_data = we_q ? wdata_q : mem.mem_rdata;
        end
      end
      DONE: begin
        if (!we_q) data_out = rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mem_write;
        addr_q  <= {data_address[ADDR_W-1:2], 2'b00};
        wdata_q <= data_in;
      end
      if (state_q == BUSY && mem.mem_ack) begin
        req_q <= 1'b0;
        if (!we_q) rdata_q <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
